instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Writer side of the instruction path: accepts symbolic instruction requests (operation, register fields, immediate/target) over a valid/ready handshake. Encodes each request into a 32-bit MIPS word and writes the words sequentially into instruction memory from address 0. It is the encoder that produces the opcode/funct fields the control decoder consumes, and is used for boot-time program loading and for self-test program generation.

## Interface
- ADDR_W, 6, instruction-memory word-address width; capacity 2^ADDR_W words
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load session at address 0
- finish  in  1  one-cycle pulse; ends the current session
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 J; 10-15 illegal
- req_rs, req_rt, req_rd  in  5 each  register fields
- req_imm  in  16  immediate (I-type)
- req_target  in  26  jump target (J)
- imem_we  out  1  write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written this session
- done  out  1  session complete (finish or memory full)
- err  out  1  sticky; an illegal req_op was accepted this session

## Operation
- States: IDLE, LOAD, DONE. Reset -> IDLE.
- IDLE: start -> LOAD, count=0, err=0.
- LOAD: req_ready = 1 while count < 2^ADDR_W. A handshake (req_valid & req_ready) encodes the request.
  - Legal op: write the word at address count, then count+1.
  - Illegal op: consumed, no write, count unchanged, err set.
- Encoding:
  - R-type: {000000, rs, rt, rd, 00000, funct}, with funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - LW: {100011, rs, rt, imm}. SW: {101011, rs, rt, imm}. BEQ: {000100, rs, rt, imm}. ADDI: {001000, rs, rt, imm}.
  - J: {000010, target}.
- LOAD -> DONE on finish, or when count reaches 2^ADDR_W.
- DONE: done=1, req_ready=0. start -> LOAD with count=0 and err=0. finish is ignored.
- start is ignored in LOAD. finish is ignored in IDLE.

## Timing
- Reset values: req_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, count 0, done 0, err 0, state IDLE.
- Reset is asynchronous. Asserting rst_n mid-session drops imem_we immediately and abandons any pending write.
- Latency: handshake in cycle N -> imem_we=1 with imem_addr/imem_wdata valid in cycle N+1. count increments in N+1. err sets in N+1.
- Throughput is one word per cycle; back-to-back handshakes give consecutive write cycles.
- req_ready is registered state, not combinational from req_valid.
- req_ready drops in the cycle after the handshake that will fill the last address (2^ADDR_W-1). That write still completes; DONE follows in the same cycle as the write.
- finish and a handshake in the same cycle: the request is accepted and written in N+1, and DONE is entered in N+1.
- imem_addr and imem_wdata hold their last values when imem_we=0.

## Structure
- Shared package mips_pkg holds:
  - req_op encodings
  - opcode constants (R-type, LW, SW, BEQ, ADDI, J)
  - funct constants
  - The same opcode/funct constants are used by the control decoder so encoder and decoder cannot diverge.
- Sub-module instr_field_encoder is purely combinational: (op, rs, rt, rd, imm, target) -> (word, illegal).
- The top level holds the FSM, address counter and output registers.

## Test plan
- Reset, then start, then ADD rs=1 rt=2 rd=3 -> one cycle later imem_we=1, imem_addr=0, imem_wdata=0x00221820, count=1.
- Back-to-back LW rs=0 rt=8 imm=4, then BEQ rs=1 rt=2 imm=0xFFFF, then J target=0x0000010 -> words 0x8C080004, 0x1022FFFF, 0x08000010 at addresses 0..2 on three consecutive cycles.
- Illegal req_op=12, then SW rs=29 rt=31 imm=8 -> err=1, no write for op 12, then 0xAFBF0008 at address 0.
- ADDR_W=2 with 5 valid requests -> 4 writes (addresses 0..3), req_ready low after the 4th handshake, done=1, count=4; the 5th request is never accepted.
- finish coincident with a SUB rs=4 rt=5 rd=6 handshake -> 0x00853022 written, then done=1. A later start clears count and err and sets req_ready=1.
- rst_n asserted in the cycle after a handshake -> imem_we=0 immediately, all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: request op codes, MIPS opcode/funct constants and loader states
// shared by the instruction encoder and the control decoder.
package mips_pkg;
   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_SLT  = 4'd4,
      OP_LW   = 4'd5,
      OP_SW   = 4'd6,
      OP_BEQ  = 4'd7,
      OP_ADDI = 4'd8,
      OP_J    = 4'd9
   } req_op_e;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] OPC_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;
endpackage

// File: rtl/instr_field_encoder.sv
// instr_field_encoder: combinational request-to-MIPS-word encoder; flags
// op codes outside the supported set as illegal.
module instr_field_encoder
   import mips_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        illegal
);
   logic [25:0] r_head;
   logic [25:0] i_tail;
   assign r_head = {OPC_RTYPE, rs, rt, rd, 5'd0};
   assign i_tail = {rs, rt, imm};
   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (op)
         OP_ADD:  word = {r_head, FUNCT_ADD};
         OP_SUB:  word = {r_head, FUNCT_SUB};
         OP_AND:  word = {r_head, FUNCT_AND};
         OP_OR:   word = {r_head, FUNCT_OR};
         OP_SLT:  word = {r_head, FUNCT_SLT};
         OP_LW:   word = {OPC_LW, i_tail};
         OP_SW:   word = {OPC_SW, i_tail};
         OP_BEQ:  word = {OPC_BEQ, i_tail};
         OP_ADDI: word = {OPC_ADDI, i_tail};
         OP_J:    word = {OPC_J, target};
         default: illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts symbolic instruction requests and writes their
// encoded words sequentially into instruction memory from address 0.
module instr_encoder_loader
   import mips_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              finish,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   input  logic [15:0]       req_imm,
   input  logic [25:0]       req_target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              err
);
   localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
   state_e      state;
   logic [31:0] word;
   logic        illegal;
   logic        hs;
   logic        wr;
   assign hs = req_valid & req_ready;
   assign wr = hs & ~illegal;
   instr_field_encoder u_enc (
      .op      (req_op),
      .rs      (req_rs),
      .rt      (req_rt),
      .rd      (req_rd),
      .imm     (req_imm),
      .target  (req_target),
      .word    (word),
      .illegal (illegal)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         req_ready  <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         count      <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state     <= S_LOAD;
                  req_ready <= 1'b1;
                  count     <= '0;
                  done      <= 1'b0;
                  err       <= 1'b0;
               end
            end
            S_LOAD: begin
               if (hs && illegal)
                  err <= 1'b1;
               if (wr) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= count[ADDR_W-1:0];
                  imem_wdata <= word;
                  count      <= count + 1'b1;
               end
               // filling the last address closes the session alongside its write
               if (finish || (wr && count == LAST)) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  req_ready <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed, table-driven checks of encoding, addressing,
// session control and reset, on a 64-word and a 4-word instance.
module tb_instr_encoder_loader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        finish = 1'b0;
   logic        req_valid = 1'b0;
   logic [3:0]  req_op = '0;
   logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0;
   logic [15:0] req_imm = '0;
   logic [25:0] req_target = '0;

   logic        b_ready, b_we, b_done, b_err;
   logic [5:0]  b_addr;
   logic [31:0] b_wdata;
   logic [6:0]  b_count;
   logic        s_ready, s_we, s_done, s_err;
   logic [1:0]  s_addr;
   logic [31:0] s_wdata;
   logic [2:0]  s_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_W(6)) u_big (
      .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
      .req_valid(req_valid), .req_ready(b_ready), .req_op(req_op),
      .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
      .req_target(req_target), .imem_we(b_we), .imem_addr(b_addr),
      .imem_wdata(b_wdata), .count(b_count), .done(b_done), .err(b_err)
   );

   instr_encoder_loader #(.ADDR_W(2)) u_small (
      .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
      .req_valid(req_valid), .req_ready(s_ready), .req_op(req_op),
      .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
      .req_target(req_target), .imem_we(s_we), .imem_addr(s_addr),
      .imem_wdata(s_wdata), .count(s_count), .done(s_done), .err(s_err)
   );

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic [31:0] word;
      logic        ill;
   } vec_t;
   vec_t vt[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
      req_valid  = 1'b1;
      req_op     = op;
      req_rs     = rs;
      req_rt     = rt;
      req_rd     = rd;
      req_imm    = imm;
      req_target = tgt;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_finish();
      finish = 1'b1;
      step();
      finish = 1'b0;
   endtask

   initial begin
      logic       exp_err;
      logic [6:0] exp_cnt;
      // unused fields carry ones so any leakage into the word shows up
      vt[0]  = '{4'd2,  5'd7,  5'd8,  5'd9,  16'hFFFF, 26'h3FFFFFF, 32'h00E84824, 1'b0};
      vt[1]  = '{4'd3,  5'd31, 5'd0,  5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h03E0F825, 1'b0};
      vt[2]  = '{4'd4,  5'd2,  5'd3,  5'd1,  16'hFFFF, 26'h3FFFFFF, 32'h0043082A, 1'b0};
      vt[3]  = '{4'd0,  5'd0,  5'd0,  5'd0,  16'hFFFF, 26'h3FFFFFF, 32'h00000020, 1'b0};
      vt[4]  = '{4'd1,  5'd1,  5'd1,  5'd1,  16'hFFFF, 26'h3FFFFFF, 32'h00210822, 1'b0};
      vt[5]  = '{4'd10, 5'd3,  5'd3,  5'd3,  16'h1234, 26'h0000123, 32'h00000000, 1'b1};
      vt[6]  = '{4'd5,  5'd31, 5'd31, 5'd31, 16'h8000, 26'h3FFFFFF, 32'h8FFF8000, 1'b0};
      vt[7]  = '{4'd6,  5'd0,  5'd0,  5'd31, 16'h0000, 26'h3FFFFFF, 32'hAC000000, 1'b0};
      vt[8]  = '{4'd7,  5'd3,  5'd4,  5'd31, 16'h0010, 26'h3FFFFFF, 32'h10640010, 1'b0};
      vt[9]  = '{4'd8,  5'd29, 5'd29, 5'd31, 16'hFFF8, 26'h3FFFFFF, 32'h23BDFFF8, 1'b0};
      vt[10] = '{4'd9,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0BFFFFFF, 1'b0};
      vt[11] = '{4'd15, 5'd1,  5'd2,  5'd3,  16'h0001, 26'h0000001, 32'h00000000, 1'b1};

      step();
      step();
      chk("rst ready", {31'd0, b_ready}, 0);
      chk("rst we", {31'd0, b_we}, 0);
      chk("rst addr", {26'd0, b_addr}, 0);
      chk("rst wdata", b_wdata, 0);
      chk("rst count", {25'd0, b_count}, 0);
      chk("rst done", {31'd0, b_done}, 0);
      chk("rst err", {31'd0, b_err}, 0);
      rst_n = 1'b1;
      step();

      // single ADD
      pulse_start();
      chk("start ready", {31'd0, b_ready}, 1);
      drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      step();
      req_valid = 1'b0;
      chk("add we", {31'd0, b_we}, 1);
      chk("add addr", {26'd0, b_addr}, 0);
      chk("add word", b_wdata, 32'h00221820);
      chk("add count", {25'd0, b_count}, 1);
      pulse_finish();
      chk("fin done", {31'd0, b_done}, 1);
      chk("fin ready", {31'd0, b_ready}, 0);

      // back-to-back LW, BEQ, J
      pulse_start();
      drive(4'd5, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0);
      step();
      chk("lw we", {31'd0, b_we}, 1);
      chk("lw addr", {26'd0, b_addr}, 0);
      chk("lw word", b_wdata, 32'h8C080004);
      drive(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
      step();
      chk("beq we", {31'd0, b_we}, 1);
      chk("beq addr", {26'd0, b_addr}, 1);
      chk("beq word", b_wdata, 32'h1022FFFF);
      drive(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010);
      step();
      req_valid = 1'b0;
      chk("j we", {31'd0, b_we}, 1);
      chk("j addr", {26'd0, b_addr}, 2);
      chk("j word", b_wdata, 32'h08000010);
      step();
      chk("idle we", {31'd0, b_we}, 0);
      chk("hold addr", {26'd0, b_addr}, 2);
      chk("hold word", b_wdata, 32'h08000010);
      chk("b2b count", {25'd0, b_count}, 3);
      pulse_start();
      chk("start in load", {25'd0, b_count}, 3);
      pulse_finish();

      // illegal op then SW, then SUB coincident with finish
      pulse_start();
      drive(4'd12, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
      step();
      chk("ill err", {31'd0, b_err}, 1);
      chk("ill we", {31'd0, b_we}, 0);
      chk("ill count", {25'd0, b_count}, 0);
      drive(4'd6, 5'd29, 5'd31, 5'd0, 16'h0008, 26'h0);
      step();
      chk("sw we", {31'd0, b_we}, 1);
      chk("sw addr", {26'd0, b_addr}, 0);
      chk("sw word", b_wdata, 32'hAFBF0008);
      chk("err sticky", {31'd0, b_err}, 1);
      drive(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
      finish = 1'b1;
      step();
      finish = 1'b0;
      req_valid = 1'b0;
      chk("sub we", {31'd0, b_we}, 1);
      chk("sub addr", {26'd0, b_addr}, 1);
      chk("sub word", b_wdata, 32'h00853022);
      chk("sub done", {31'd0, b_done}, 1);
      chk("sub ready", {31'd0, b_ready}, 0);
      pulse_finish();
      chk("fin in done", {31'd0, b_done}, 1);
      pulse_start();
      chk("restart count", {25'd0, b_count}, 0);
      chk("restart err", {31'd0, b_err}, 0);
      chk("restart ready", {31'd0, b_ready}, 1);
      chk("restart done", {31'd0, b_done}, 0);

      // fill the 4-word instance with 5 requests
      for (int k = 0; k < 5; k++) begin
         drive(4'd8, 5'd1, 5'd2, 5'd0, 16'(k), 26'h0);
         step();
         if (k < 4) begin
            chk($sformatf("full we%0d", k), {31'd0, s_we}, 1);
            chk($sformatf("full addr%0d", k), {30'd0, s_addr}, k);
            chk($sformatf("full word%0d", k), s_wdata, 32'h20220000 | k);
         end else
            chk("full 5th we", {31'd0, s_we}, 0);
         chk($sformatf("full ready%0d", k), {31'd0, s_ready}, k < 3 ? 1 : 0);
      end
      req_valid = 1'b0;
      chk("full done", {31'd0, s_done}, 1);
      chk("full count", {29'd0, s_count}, 4);
      pulse_finish();

      // encoding table in one session
      pulse_start();
      exp_err = 1'b0;
      exp_cnt = '0;
      for (int i = 0; i < 12; i++) begin
         drive(vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].imm, vt[i].tgt);
         step();
         exp_err |= vt[i].ill;
         chk($sformatf("tab we%0d", i), {31'd0, b_we}, {31'd0, ~vt[i].ill});
         chk($sformatf("tab err%0d", i), {31'd0, b_err}, {31'd0, exp_err});
         if (!vt[i].ill) begin
            chk($sformatf("tab word%0d", i), b_wdata, vt[i].word);
            chk($sformatf("tab addr%0d", i), {26'd0, b_addr}, {25'd0, exp_cnt});
            exp_cnt++;
         end
         chk($sformatf("tab count%0d", i), {25'd0, b_count}, {25'd0, exp_cnt});
      end
      req_valid = 1'b0;

      // asynchronous reset right after a handshake
      drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      step();
      req_valid = 1'b0;
      chk("pre-rst we", {31'd0, b_we}, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst we", {31'd0, b_we}, 0);
      chk("arst addr", {26'd0, b_addr}, 0);
      chk("arst wdata", b_wdata, 0);
      chk("arst count", {25'd0, b_count}, 0);
      chk("arst ready", {31'd0, b_ready}, 0);
      chk("arst err", {31'd0, b_err}, 0);
      step();
      rst_n = 1'b1;
      drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      finish = 1'b1;
      step();
      finish = 1'b0;
      req_valid = 1'b0;
      chk("idle no write", {31'd0, b_we}, 0);
      chk("idle fin done", {31'd0, b_done}, 0);
      chk("idle ready", {31'd0, b_ready}, 0);
      pulse_start();
      chk("post-rst ready", {31'd0, b_ready}, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
